// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed scan controller for an N-digit common-bus 7-segment
//   display. One shared nibble (bcd_out) feeds an external hex-to-7seg
//   decoder. The one-hot digit enables step through the digits. Each digit
//   slot starts with a blanking guard (all digits off) so the decoder can
//   settle on the new nibble without ghosting into the previous digit.
//
// Ports
//   clk, rst_n   clock and asynchronous active-low reset
//   enable       1 = scanning, 0 = all digits off (FSM parks in IDLE)
//   lz_suppress  1 = blank leading-zero digits (digit 0 is always shown)
//   load         1-cycle strobe capturing value_in / dp_in into the shadow regs
//   value_in     nibble k is the hex value of digit k (digit 0 = LS digit)
//   dp_in        decimal point per digit
//   load_ack     1-cycle pulse when the shadow value is committed to display
//   bcd_out      nibble of the digit currently being scanned
//   dp_out       decimal point of the digit currently being scanned
//   digit_en     one-hot digit drive, EN_ACTIVE polarity
//   frame_tick   1-cycle pulse on the first cycle of the digit 0 slot
//
// Handshake: load has no ready. Every load strobe is accepted into the
// shadow registers, and a newer load overwrites an uncommitted one. The
// shadow value moves to the display registers only at a frame boundary, or
// while the FSM is idle, so a frame never shows a mix of old and new digits.
// load_ack pulses once per commit, not once per load.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 12000,
  parameter int BLANK_CYCLES = 16,
  parameter bit EN_ACTIVE    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      lz_suppress,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  output logic                      load_ack,
  output logic [3:0]                bcd_out,
  output logic                      dp_out,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      frame_tick
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{~EN_ACTIVE}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0]   shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic                      pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0]   disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]     disp_dp_q, disp_dp_d;
  logic [3:0]                bcd_q, bcd_d;
  logic                      dp_q, dp_d;
  logic [NUM_DIGITS-1:0]     en_q, en_d;
  logic                      ack_q, ack_d;
  logic                      tick_q, tick_d;

  logic                      commit;
  logic                      frame_start;
  logic                      run_zero;
  logic [NUM_DIGITS-1:0]     supp;
  logic [NUM_DIGITS-1:0]     onehot;

  // Leading-zero suppression. Walk down from the most significant digit.
  // A digit stays dark while it and every digit above it are zero with no
  // decimal point. Digit 0 is never considered.
  always_comb begin
    run_zero = lz_suppress;
    supp     = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      run_zero = run_zero & (disp_val_q[k*4 +: 4] == 4'h0) & ~disp_dp_q[k];
      supp[k]  = run_zero;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    commit       = 1'b0;
    frame_start  = 1'b0;
    onehot       = '0;

    case (state_q)
      ST_IDLE: begin
        idx_d  = '0;
        cnt_d  = '0;
        commit = pending_q;
        if (enable) begin
          state_d     = ST_BLANK;
          frame_start = 1'b1;
        end
      end
      ST_BLANK: begin
        if (!enable) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (!enable) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == SLOT_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d       = '0;
            frame_start = 1'b1;
            commit      = pending_q;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // The commit reads the old shadow. A load on the same cycle lands in
    // the shadow and leaves pending set for the next boundary.
    if (commit) begin
      disp_val_d = shadow_val_q;
      disp_dp_d  = shadow_dp_q;
      pending_d  = 1'b0;
    end
    if (load) begin
      shadow_val_d = value_in;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end

    // Outputs are computed for the next cycle's state, so each one changes
    // on the same edge as the state it belongs to.
    bcd_d  = disp_val_d[{idx_d, 2'b00} +: 4];
    dp_d   = disp_dp_d[idx_d];
    ack_d  = commit;
    tick_d = frame_start;
    if (state_d == ST_SHOW && !supp[idx_d]) onehot[idx_d] = 1'b1;
    en_d   = EN_ACTIVE ? onehot : ~onehot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      bcd_q        <= 4'h0;
      dp_q         <= 1'b0;
      en_q         <= EN_OFF;
      ack_q        <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      bcd_q        <= bcd_d;
      dp_q         <= dp_d;
      en_q         <= en_d;
      ack_q        <= ack_d;
      tick_q       <= tick_d;
    end
  end

  assign bcd_out    = bcd_q;
  assign dp_out     = dp_q;
  assign digit_en   = en_q;
  assign load_ack   = ack_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with 4 digits, 8-cycle slots and a 2-cycle blank.
// Expected per-slot results {dp, nibble, digit_en} are queued when the
// display value is loaded. They are popped and compared while a frame is
// walked slot by slot. Every cycle advance also checks that digit_en is
// one-hot-or-zero and is zero whenever bcd_out changes.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;

  logic            clk;
  logic            rst_n;
  logic            enable;
  logic            lz_suppress;
  logic            load;
  logic [4*ND-1:0] value_in;
  logic [ND-1:0]   dp_in;
  logic            load_ack;
  logic [3:0]      bcd_out;
  logic            dp_out;
  logic [ND-1:0]   digit_en;
  logic            frame_tick;

  logic [8:0]      exp_q[$];
  int              n_cmp;
  int              n_err;
  logic [3:0]      prev_bcd;
  int              acks;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SLOT_CYCLES (8),
    .BLANK_CYCLES(2),
    .EN_ACTIVE   (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .lz_suppress(lz_suppress),
    .load       (load),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .load_ack   (load_ack),
    .bcd_out    (bcd_out),
    .dp_out     (dp_out),
    .digit_en   (digit_en),
    .frame_tick (frame_tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and run the continuous checks there.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      chk("onehot_or_zero", 32'($countones(digit_en) <= 1), 32'd1);
      if (bcd_out !== prev_bcd) chk("en_off_on_bcd_change", 32'(digit_en), 32'd0);
    end
    prev_bcd = bcd_out;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // drivers
  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    load     = 1'b1;
    value_in = v;
    dp_in    = dp;
    tick();
    load     = 1'b0;
    value_in = $urandom_range(16'hFFFF, 0);
    dp_in    = 4'($urandom_range(15, 0));
  endtask

  // Runs until the next frame_tick and reports the load_ack pulses seen
  // before that tick.
  task automatic wait_tick(output int n_ack);
    n_ack = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (frame_tick) break;
      if (load_ack) n_ack++;
    end
    chk("frame_tick_timeout", 32'(frame_tick), 32'd1);
  endtask

  // Queues the expected slot results for one frame.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] lit);
    logic [8:0] e;
    for (int s = 0; s < ND; s++) begin
      e = {dp[s], v[s*4 +: 4], lit[s] ? 4'(1 << s) : 4'b0000};
      exp_q.push_back(e);
    end
  endtask

  // Starts at the negedge carrying frame_tick and ends at the next one.
  task automatic check_frame(input string name);
    logic [8:0] e;
    for (int s = 0; s < ND; s++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_tick_s%0d", name, s), 32'(frame_tick), 32'(s == 0));
      chk($sformatf("%s_digit_s%0d", name, s), 32'({dp_out, bcd_out}), 32'(e[8:4]));
      chk($sformatf("%s_blank_s%0d", name, s), 32'(digit_en), 32'd0);
      ticks(2);
      chk($sformatf("%s_en_first_s%0d", name, s), 32'(digit_en), 32'(e[3:0]));
      ticks(5);
      chk($sformatf("%s_en_last_s%0d", name, s), 32'(digit_en), 32'(e[3:0]));
      tick();
    end
    chk($sformatf("%s_queue_drained", name), 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    enable      = 1'b0;
    lz_suppress = 1'b0;
    load        = 1'b0;
    value_in    = '0;
    dp_in       = '0;
    prev_bcd    = 4'h0;

    // 1: reset values, first frame, reset asserted in the middle of SHOW
    ticks(2);
    chk("rst_en", 32'(digit_en), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_ack", 32'(load_ack), 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    wait_tick(acks);
    chk("first_tick_ack", 32'(load_ack), 32'd0);
    push_frame(16'h0000, 4'b0000, 4'b1111);
    check_frame("f_zero");
    ticks(4);
    chk("mid_show_en", 32'(digit_en), 32'b0001);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_en", 32'(digit_en), 32'd0);
    chk("async_rst_bcd", 32'(bcd_out), 32'd0);
    chk("async_rst_dp", 32'(dp_out), 32'd0);
    chk("async_rst_ack", 32'(load_ack), 32'd0);
    chk("async_rst_tick", 32'(frame_tick), 32'd0);
    tick();
    rst_n = 1'b1;
    wait_tick(acks);

    // 2: a load mid-frame commits only at the next frame boundary
    ticks(10);
    do_load(16'h12AB, 4'b0100);
    chk("pre_commit_bcd", 32'(bcd_out), 32'h0);
    chk("pre_commit_ack", 32'(load_ack), 32'd0);
    wait_tick(acks);
    chk("early_ack_count", 32'(acks), 32'd0);
    chk("commit_ack", 32'(load_ack), 32'd1);
    push_frame(16'h12AB, 4'b0100, 4'b1111);
    check_frame("f_12ab");

    // 3: two loads in one frame give a single ack and the later value
    ticks(3);
    do_load(16'h1111, 4'b0000);
    ticks(5);
    do_load(16'h2222, 4'b0000);
    wait_tick(acks);
    chk("dbl_early_ack", 32'(acks), 32'd0);
    chk("dbl_commit_ack", 32'(load_ack), 32'd1);
    push_frame(16'h2222, 4'b0000, 4'b1111);
    check_frame("f_2222");
    chk("dbl_no_second_ack", 32'(load_ack), 32'd0);

    // 4: leading-zero suppression
    lz_suppress = 1'b1;
    do_load(16'h0005, 4'b0000);
    wait_tick(acks);
    chk("lz_ack", 32'(load_ack), 32'd1);
    push_frame(16'h0005, 4'b0000, 4'b0001);
    check_frame("f_lz5");
    lz_suppress = 1'b0;
    push_frame(16'h0005, 4'b0000, 4'b1111);
    check_frame("f_nolz5");
    lz_suppress = 1'b1;
    do_load(16'h0005, 4'b0100);
    wait_tick(acks);
    push_frame(16'h0005, 4'b0100, 4'b0111);
    check_frame("f_lz5dp");
    do_load(16'h0000, 4'b0000);
    wait_tick(acks);
    push_frame(16'h0000, 4'b0000, 4'b0001);
    check_frame("f_lz0");

    // 5: disable mid-SHOW, load while idle, restart
    lz_suppress = 1'b0;
    ticks(4);
    chk("dis_pre_en", 32'(digit_en), 32'b0001);
    enable = 1'b0;
    tick();
    chk("dis_en_off", 32'(digit_en), 32'd0);
    do_load(16'h4321, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (load_ack) break;
    end
    chk("idle_ack", 32'(load_ack), 32'd1);
    chk("idle_commit_bcd", 32'(bcd_out), 32'h1);
    enable = 1'b1;
    wait_tick(acks);
    chk("reen_no_ack", 32'(load_ack), 32'd0);
    push_frame(16'h4321, 4'b0000, 4'b1111);
    check_frame("f_4321");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
